div_issue_ctrl: RTL and testbench

EX-stage initiator for the iterative multi-cycle divider. It accepts DIV/DIVU from the EX stage and drives the divider's start/annul/operand handshake. It stalls the front of the pipeline while the divide is in flight, absorbs the divider's one-cycle ready pulse into a held HI/LO result, and guarantees a clean divider state after a flush before the next divide is issued.

---
 rtl/div_issue_ctrl_pkg.sv | 18 +
 rtl/div_issue_ctrl_if.sv | 24 ++
 rtl/div_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared constants and types for the EX-stage divider issue controller.
package div_issue_ctrl_pkg;

  localparam int DIV_DATA_W       = 32;
  localparam int DIV_DRAIN_CYCLES = 2;
  localparam int DIV_DRAIN_CNT_W  = $clog2(DIV_DRAIN_CYCLES + 1);

  // LO value returned by the fast zero-divisor path.
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } div_ctrl_state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake between the issue controller (master) and the iterative divider
// (slave): start/annul/operands out, {remainder, quotient} and ready back.
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic                    div_start;
  logic                    div_annul;
  logic                    div_signed;
  logic [DIV_DATA_W-1:0]   div_op1;
  logic [DIV_DATA_W-1:0]   div_op2;
  logic [2*DIV_DATA_W-1:0] div_result;
  logic                    div_ready;

  modport master (
    output div_start, div_annul, div_signed, div_op1, div_op2,
    input  div_result, div_ready
  );

  modport slave (
    input  div_start, div_annul, div_signed, div_op1, div_op2,
    output div_result, div_ready
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider. Issues DIV/DIVU, stalls the
// front end while the divide runs, holds the HI/LO result until consumed, and
// drains the divider after a flush before the next issue.
// Optional feature: define DIV_FAST_ZERO_EN to answer zero divisors locally
// (HI = dividend, LO = all ones) without starting the divider.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_div_valid,
  input  logic                  ex_div_signed,
  input  logic [DIV_DATA_W-1:0] ex_op1,
  input  logic [DIV_DATA_W-1:0] ex_op2,
  input  logic                  flush,
  input  logic                  downstream_stall,
  output logic                  div_stall,
  output logic                  div_result_valid,
  output logic [DIV_DATA_W-1:0] div_hi,
  output logic [DIV_DATA_W-1:0] div_lo,
  div_issue_ctrl_if.master      dbus
);

  div_ctrl_state_t             state;
  div_ctrl_state_t             state_next;
  logic [DIV_DRAIN_CNT_W-1:0]  drain_cnt;
  logic                        drain_last;
  logic [DIV_DATA_W-1:0]       op1_q;
  logic [DIV_DATA_W-1:0]       op2_q;
  logic                        signed_q;
  logic                        issue;
  logic                        capture;
  logic                        start_c;
  logic                        annul_c;
`ifdef DIV_FAST_ZERO_EN
  logic                        fast_zero;
`endif

  assign drain_last = (drain_cnt == DIV_DRAIN_CNT_W'(DIV_DRAIN_CYCLES - 1));

  // Operands and sign stay frozen from issue through completion because the
  // divider re-reads the sign bits when it finishes.
  assign dbus.div_op1    = op1_q;
  assign dbus.div_op2    = op2_q;
  assign dbus.div_signed = signed_q;
  assign dbus.div_start  = start_c;
  assign dbus.div_annul  = annul_c;

  // Next-state and handshake decode; start drops in the same cycle ready is
  // seen so a free divider never resamples it.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next       = state;
    div_stall        = 1'b0;
    div_result_valid = 1'b0;
    start_c          = 1'b0;
    annul_c          = 1'b0;
    issue            = 1'b0;
    capture          = 1'b0;
`ifdef DIV_FAST_ZERO_EN
    fast_zero        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ex_div_valid && !flush) begin
          div_stall = 1'b1;
          issue     = 1'b1;
`ifdef DIV_FAST_ZERO_EN
          if (ex_op2 == '0) begin
            fast_zero  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        div_stall = 1'b1;
        start_c   = !dbus.div_ready && !flush;
        // A flush wins over a coincident ready: the result is dropped.
        if (flush) begin
          annul_c    = 1'b1;
          state_next = DRAIN;
        end else if (dbus.div_ready) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        div_result_valid = !flush;
        if (flush || !downstream_stall) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // Let a divider parked in its zero-divide/end state settle to free.
        div_stall = ex_div_valid;
        if (drain_last) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // State, drain counter, operand latch and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      signed_q  <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state <= state_next;
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
      if (issue) begin
        op1_q    <= ex_op1;
        op2_q    <= ex_op2;
        signed_q <= ex_div_signed;
      end
      if (capture) begin
        div_hi <= dbus.div_result[2*DIV_DATA_W-1:DIV_DATA_W];
        div_lo <= dbus.div_result[DIV_DATA_W-1:0];
      end
`ifdef DIV_FAST_ZERO_EN
      if (fast_zero) begin
        div_hi <= ex_op1;
        div_lo <= DIV_ZERO_LO;
      end
`endif
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative divider
// (ready 35 cycles after start is first seen high, i.e. at T36).
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_div_valid;
  logic        ex_div_signed;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        flush;
  logic        downstream_stall;
  logic        div_stall;
  logic        div_result_valid;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  int tests = 0;
  int fails = 0;

  div_issue_ctrl_if dbus();

  div_issue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ex_div_valid     (ex_div_valid),
    .ex_div_signed    (ex_div_signed),
    .ex_op1           (ex_op1),
    .ex_op2           (ex_op2),
    .flush            (flush),
    .downstream_stall (downstream_stall),
    .div_stall        (div_stall),
    .div_result_valid (div_result_valid),
    .div_hi           (div_hi),
    .div_lo           (div_lo),
    .dbus             (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model
  localparam int RUN_LEN = 34;
  logic        m_busy;
  logic [7:0]  m_cnt;
  logic        m_ready;
  logic [63:0] m_result;
  logic        inj_ready = 1'b0;
  logic [63:0] inj_result = '0;
  int          runs = 0;

  assign dbus.div_ready  = m_ready | inj_ready;
  assign dbus.div_result = inj_ready ? inj_result : m_result;

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy   <= 1'b0;
      m_cnt    <= '0;
      m_ready  <= 1'b0;
      m_result <= '0;
    end else begin
      m_ready <= 1'b0;
      if (dbus.div_annul) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 8'(RUN_LEN - 1)) begin
          m_ready  <= 1'b1;
          m_busy   <= 1'b0;
          m_result <= model_div(dbus.div_signed, dbus.div_op1, dbus.div_op2);
        end else begin
          m_cnt <= m_cnt + 8'd1;
        end
      end else if (dbus.div_start) begin
        m_busy <= 1'b1;
        m_cnt  <= '0;
        runs   <= runs + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents an instruction for one cycle (T0); returns at T1 + 1.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, output logic stall_t0);
    ex_div_valid  = 1'b1;
    ex_div_signed = sgn;
    ex_op1        = a;
    ex_op2        = b;
    #1;
    stall_t0 = div_stall;
    @(negedge clk);
    ex_div_valid = 1'b0;
    #1;
  endtask

  // Called at T1; returns at the cycle valid is seen (or -1 on timeout).
  task automatic wait_result(input int max, output int t_valid, output int t_ready, output logic start_at_ready);
    t_valid = -1;
    t_ready = -1;
    start_at_ready = 1'b1;
    for (int t = 1; t <= max; t++) begin
      if (dbus.div_ready && t_ready < 0) begin
        t_ready = t;
        start_at_ready = dbus.div_start;
      end
      if (div_result_valid) begin
        t_valid = t;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_div_valid = 1'b0; ex_div_signed = 1'b0; ex_op1 = '0; ex_op2 = '0;
    flush = 1'b0; downstream_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", div_stall); end
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", div_result_valid); end
    tests++; if (div_hi !== 32'd0) begin fails++; $display("FAIL reset_hi got=%h exp=0", div_hi); end
    tests++; if (div_lo !== 32'd0) begin fails++; $display("FAIL reset_lo got=%h exp=0", div_lo); end
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL reset_start got=%b exp=0", dbus.div_start); end
    tests++; if (dbus.div_annul !== 1'b0) begin fails++; $display("FAIL reset_annul got=%b exp=0", dbus.div_annul); end
    tests++; if (dbus.div_signed !== 1'b0) begin fails++; $display("FAIL reset_signed got=%b exp=0", dbus.div_signed); end
    tests++; if (dbus.div_op1 !== 32'd0) begin fails++; $display("FAIL reset_op1 got=%h exp=0", dbus.div_op1); end
    tests++; if (dbus.div_op2 !== 32'd0) begin fails++; $display("FAIL reset_op2 got=%h exp=0", dbus.div_op2); end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_divu_basic();
    int r0, tv, tr;
    logic st0, sar;
    r0 = runs;
    issue(1'b0, 32'd100, 32'd7, st0);
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL divu_stall_t0 got=%b exp=1", st0); end
    tests++; if (dbus.div_start !== 1'b1) begin fails++; $display("FAIL divu_start_t1 got=%b exp=1", dbus.div_start); end
    tests++; if (dbus.div_op1 !== 32'd100) begin fails++; $display("FAIL divu_op1 got=%h exp=%h", dbus.div_op1, 32'd100); end
    tests++; if (dbus.div_op2 !== 32'd7) begin fails++; $display("FAIL divu_op2 got=%h exp=%h", dbus.div_op2, 32'd7); end
    tests++; if (dbus.div_signed !== 1'b0) begin fails++; $display("FAIL divu_signed got=%b exp=0", dbus.div_signed); end
    wait_result(60, tv, tr, sar);
    tests++; if (tr !== 36) begin fails++; $display("FAIL divu_ready_cycle got=%0d exp=36", tr); end
    tests++; if (sar !== 1'b0) begin fails++; $display("FAIL divu_start_at_ready got=%b exp=0", sar); end
    tests++; if (tv !== 37) begin fails++; $display("FAIL divu_valid_cycle got=%0d exp=37", tv); end
    tests++; if (div_hi !== 32'd2) begin fails++; $display("FAIL divu_hi got=%h exp=%h", div_hi, 32'd2); end
    tests++; if (div_lo !== 32'd14) begin fails++; $display("FAIL divu_lo got=%h exp=%h", div_lo, 32'd14); end
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL divu_stall_done got=%b exp=0", div_stall); end
    tests++; if (runs - r0 !== 1) begin fails++; $display("FAIL divu_runs got=%0d exp=1", runs - r0); end
    @(negedge clk); #1;
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL divu_consumed got=%b exp=0", div_result_valid); end
    tests++; if (runs - r0 !== 1) begin fails++; $display("FAIL divu_runs_after got=%0d exp=1", runs - r0); end
  endtask

  task automatic test_div_signed();
    int tv, tr;
    logic st0, sar;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, st0);
    tests++; if (dbus.div_signed !== 1'b1) begin fails++; $display("FAIL sdiv_signed got=%b exp=1", dbus.div_signed); end
    wait_result(60, tv, tr, sar);
    tests++; if (tv !== 37) begin fails++; $display("FAIL sdiv_valid_cycle got=%0d exp=37", tv); end
    tests++; if (div_hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sdiv_hi got=%h exp=ffffffff", div_hi); end
    tests++; if (div_lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL sdiv_lo got=%h exp=fffffffd", div_lo); end
    @(negedge clk); #1;
  endtask

  task automatic test_downstream_stall();
    int tv, tr;
    logic st0, sar;
    issue(1'b0, 32'd50, 32'd8, st0);
    downstream_stall = 1'b1;
    wait_result(60, tv, tr, sar);
    tests++; if (tv !== 37) begin fails++; $display("FAIL hold_valid_cycle got=%0d exp=37", tv); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (div_result_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, div_result_valid); end
      tests++; if (div_hi !== 32'd2) begin fails++; $display("FAIL hold_hi[%0d] got=%h exp=2", i, div_hi); end
      tests++; if (div_lo !== 32'd6) begin fails++; $display("FAIL hold_lo[%0d] got=%h exp=6", i, div_lo); end
      tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL hold_stall[%0d] got=%b exp=0", i, div_stall); end
      if (i == 4) downstream_stall = 1'b0;
      @(negedge clk); #1;
    end
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL hold_release got=%b exp=0", div_result_valid); end
  endtask

  task automatic test_flush_busy();
    int r0, tv, tr;
    logic st0, sar;
    r0 = runs;
    issue(1'b1, 32'd20, 32'd3, st0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    tests++; if (dbus.div_annul !== 1'b1) begin fails++; $display("FAIL flush_annul got=%b exp=1", dbus.div_annul); end
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL flush_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_stall !== 1'b1) begin fails++; $display("FAIL flush_stall got=%b exp=1", div_stall); end
    @(negedge clk);
    flush = 1'b0;
    ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_op1 = 32'd9; ex_op2 = 32'd4;
    #1;
    tests++; if (dbus.div_annul !== 1'b0) begin fails++; $display("FAIL drain1_annul got=%b exp=0", dbus.div_annul); end
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL drain1_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_stall !== 1'b1) begin fails++; $display("FAIL drain1_stall got=%b exp=1", div_stall); end
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL drain1_valid got=%b exp=0", div_result_valid); end
    @(negedge clk); #1;
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL drain2_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_stall !== 1'b1) begin fails++; $display("FAIL drain2_stall got=%b exp=1", div_stall); end
    @(negedge clk); #1;
    tests++; if (div_stall !== 1'b1) begin fails++; $display("FAIL reissue_stall got=%b exp=1", div_stall); end
    tests++; if (dbus.div_op1 !== 32'd20) begin fails++; $display("FAIL reissue_op1_early got=%h exp=%h", dbus.div_op1, 32'd20); end
    @(negedge clk);
    ex_div_valid = 1'b0;
    #1;
    tests++; if (dbus.div_start !== 1'b1) begin fails++; $display("FAIL reissue_start got=%b exp=1", dbus.div_start); end
    tests++; if (dbus.div_op1 !== 32'd9) begin fails++; $display("FAIL reissue_op1 got=%h exp=%h", dbus.div_op1, 32'd9); end
    wait_result(60, tv, tr, sar);
    tests++; if (tv !== 37) begin fails++; $display("FAIL reissue_valid_cycle got=%0d exp=37", tv); end
    tests++; if (div_hi !== 32'd1) begin fails++; $display("FAIL reissue_hi got=%h exp=1", div_hi); end
    tests++; if (div_lo !== 32'd2) begin fails++; $display("FAIL reissue_lo got=%h exp=2", div_lo); end
    tests++; if (runs - r0 !== 2) begin fails++; $display("FAIL reissue_runs got=%0d exp=2", runs - r0); end
    @(negedge clk); #1;
  endtask

  task automatic test_flush_at_ready();
    int r0, found;
    logic st0;
    r0 = runs;
    found = 0;
    issue(1'b0, 32'd100, 32'd7, st0);
    for (int t = 1; t <= 60; t++) begin
      if (dbus.div_ready) begin
        found = 1;
        break;
      end
      @(negedge clk); #1;
    end
    tests++; if (found !== 1) begin fails++; $display("FAIL fr_ready_seen got=%0d exp=1", found); end
    flush = 1'b1;
    #1;
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL fr_start got=%b exp=0", dbus.div_start); end
    tests++; if (dbus.div_annul !== 1'b1) begin fails++; $display("FAIL fr_annul got=%b exp=1", dbus.div_annul); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL fr_valid1 got=%b exp=0", div_result_valid); end
    tests++; if (dbus.div_annul !== 1'b0) begin fails++; $display("FAIL fr_annul_drain got=%b exp=0", dbus.div_annul); end
    @(negedge clk); #1;
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL fr_valid2 got=%b exp=0", div_result_valid); end
    @(negedge clk); #1;
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL fr_valid3 got=%b exp=0", div_result_valid); end
    tests++; if (div_hi !== 32'd1) begin fails++; $display("FAIL fr_hi_kept got=%h exp=1", div_hi); end
    tests++; if (div_lo !== 32'd2) begin fails++; $display("FAIL fr_lo_kept got=%h exp=2", div_lo); end
    tests++; if (runs - r0 !== 1) begin fails++; $display("FAIL fr_runs got=%0d exp=1", runs - r0); end
  endtask

  task automatic test_zero_div();
    int r0;
    logic st0;
`ifdef DIV_FAST_ZERO_EN
    r0 = runs;
    issue(1'b0, 32'd123, 32'd0, st0);
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL z_stall_t0 got=%b exp=1", st0); end
    tests++; if (div_result_valid !== 1'b1) begin fails++; $display("FAIL z_valid_t1 got=%b exp=1", div_result_valid); end
    tests++; if (div_hi !== 32'd123) begin fails++; $display("FAIL z_hi got=%h exp=%h", div_hi, 32'd123); end
    tests++; if (div_lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL z_lo got=%h exp=ffffffff", div_lo); end
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL z_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL z_stall_t1 got=%b exp=0", div_stall); end
    @(negedge clk); #1;
    tests++; if (runs - r0 !== 0) begin fails++; $display("FAIL z_runs got=%0d exp=0", runs - r0); end
`else
    int tv, tr;
    logic sar;
    r0 = runs;
    issue(1'b0, 32'd123, 32'd0, st0);
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL z_stall_t0 got=%b exp=1", st0); end
    wait_result(60, tv, tr, sar);
    tests++; if (tv !== 37) begin fails++; $display("FAIL z_valid_cycle got=%0d exp=37", tv); end
    tests++; if (div_hi !== 32'd0) begin fails++; $display("FAIL z_hi got=%h exp=0", div_hi); end
    tests++; if (div_lo !== 32'd0) begin fails++; $display("FAIL z_lo got=%h exp=0", div_lo); end
    tests++; if (runs - r0 !== 1) begin fails++; $display("FAIL z_runs got=%0d exp=1", runs - r0); end
    @(negedge clk); #1;
`endif
  endtask

  task automatic test_back_to_back();
    int tv, tr;
    logic st0, sar;
    issue(1'b0, 32'd100, 32'd7, st0);
    wait_result(60, tv, tr, sar);
    tests++; if (div_lo !== 32'd14) begin fails++; $display("FAIL b2b_first_lo got=%h exp=%h", div_lo, 32'd14); end
    @(negedge clk); #1;
    issue(1'b0, 32'd9, 32'd4, st0);
    tests++; if (st0 !== 1'b1) begin fails++; $display("FAIL b2b_stall_t0 got=%b exp=1", st0); end
    tests++; if (dbus.div_start !== 1'b1) begin fails++; $display("FAIL b2b_start_t1 got=%b exp=1", dbus.div_start); end
    wait_result(60, tv, tr, sar);
    tests++; if (tv !== 37) begin fails++; $display("FAIL b2b_valid_cycle got=%0d exp=37", tv); end
    tests++; if (div_hi !== 32'd1) begin fails++; $display("FAIL b2b_hi got=%h exp=1", div_hi); end
    tests++; if (div_lo !== 32'd2) begin fails++; $display("FAIL b2b_lo got=%h exp=2", div_lo); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    logic st0;
    issue(1'b0, 32'd100, 32'd7, st0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL rmb_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_stall !== 1'b0) begin fails++; $display("FAIL rmb_stall got=%b exp=0", div_stall); end
    tests++; if (dbus.div_op1 !== 32'd0) begin fails++; $display("FAIL rmb_op1 got=%h exp=0", dbus.div_op1); end
    rst = 1'b1;
    @(negedge clk);
    inj_result = {32'h1234_5678, 32'h9ABC_DEF0};
    inj_ready  = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    #1;
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL stale_valid got=%b exp=0", div_result_valid); end
    tests++; if (div_hi !== 32'd0) begin fails++; $display("FAIL stale_hi got=%h exp=0", div_hi); end
    tests++; if (div_lo !== 32'd0) begin fails++; $display("FAIL stale_lo got=%h exp=0", div_lo); end
    @(negedge clk); #1;
    tests++; if (dbus.div_start !== 1'b0) begin fails++; $display("FAIL stale_start got=%b exp=0", dbus.div_start); end
    tests++; if (div_result_valid !== 1'b0) begin fails++; $display("FAIL stale_valid2 got=%b exp=0", div_result_valid); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_downstream_stall();
    test_flush_busy();
    test_flush_at_ready();
    test_zero_div();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
